// File: rtl/object_line_buffer.sv
// Object line buffer: a double-banked scanline of object pixels.
// The back bank is built one object at a time from a pattern source while
// the front bank is read out against the display scan position.

package mapache64;

    typedef struct packed {
        logic [1:0] lightness;
        logic [3:0] color;
    } pixel_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] color;
        logic       hflip;
    } obm_object_t;

endpackage

module object_line_buffer #(
    parameter int LINE_W   = 256,
    parameter int OBJ_W    = 8,
    parameter int MAX_OBJS = 16
) (
    input  logic                         gpu_clk,
    input  logic                         rst,
    output logic                         ready_o,
    input  logic                         swap_i,
    input  logic [7:0]                   new_y_i,
    input  logic                         load_start_i,
    input  mapache64::obm_object_t       load_object_i,
    output logic [$clog2(OBJ_W)-1:0]     load_intx_o,
    output logic [$clog2(OBJ_W)-1:0]     load_inty_o,
    input  logic [1:0]                   load_lightness_i,
    input  logic [7:0]                   display_x_i,
    input  logic [7:0]                   display_y_i,
    output mapache64::pixel_t            pixel_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(LINE_W);
    localparam int IW = $clog2(OBJ_W);
    localparam int CW = $clog2(MAX_OBJS + 1);

    typedef struct packed {
        logic              occupied;
        mapache64::pixel_t pixel;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD
    } state_t;

    // Both banks in one array; the top index bit selects the bank.
    entry_t            r_mem [0:2*LINE_W-1];

    state_t            r_state;
    logic              r_ready;
    logic [AW-1:0]     r_cnt;          // clear address in CLEAR, intx counter c in LOAD
    logic [CW-1:0]     r_count;        // objects accepted onto the back line
    logic              r_overflow;
    logic              r_front_sel;
    logic              r_front_valid;
    logic [7:0]        r_front_y;
    logic [7:0]        r_back_y;
    mapache64::pixel_t r_pixel;

    mapache64::obm_object_t w_obj;
    logic [8:0]        w_obj_y9;
    logic [8:0]        w_back_y9;
    logic [8:0]        w_addr9;
    logic              w_back_sel;
    logic [AW:0]       w_back_idx;
    logic [AW:0]       w_clr_idx;
    logic [AW:0]       w_front_idx;
    logic              w_hit;
    logic              w_in_line;
    logic              w_occ;
    logic              w_first;
    logic              w_overflowing;
    logic              w_last;
    logic              w_clr_we;
    logic              w_pix_we;
    logic              w_disp_hit;

    assign w_obj      = load_object_i;
    assign w_obj_y9   = {1'b0, w_obj.y};
    assign w_back_y9  = {1'b0, r_back_y};
    // 9-bit arithmetic keeps objects near the bottom/right edge from wrapping.
    assign w_hit      = (w_obj_y9 <= w_back_y9) && (w_back_y9 <= w_obj_y9 + 9'(OBJ_W - 1));
    assign w_addr9    = {1'b0, w_obj.x} + 9'(r_cnt);
    assign w_in_line  = w_addr9 < 9'(LINE_W);

    assign w_back_sel  = ~r_front_sel;
    assign w_back_idx  = {w_back_sel, w_addr9[AW-1:0]};
    assign w_clr_idx   = {w_back_sel, r_cnt};
    assign w_front_idx = {r_front_sel, display_x_i[AW-1:0]};

    assign w_occ         = r_mem[w_back_idx].occupied;
    // The first LOAD cycle is where the object is accepted or refused.
    assign w_first       = (r_cnt == '0);
    assign w_overflowing = w_first && (r_count == CW'(MAX_OBJS));
    assign w_last        = (r_cnt == AW'(OBJ_W - 1)) || (w_addr9 == 9'(LINE_W - 1));

    assign w_clr_we = (r_state == CLEAR);
    assign w_pix_we = (r_state == LOAD) && w_hit && !w_overflowing && w_in_line &&
                      (load_lightness_i != 2'd0) && !w_occ;

    assign w_disp_hit = r_front_valid && (display_y_i == r_front_y) &&
                        ({1'b0, display_x_i} < 9'(LINE_W));

    // Pattern fetch coordinates follow the counter directly so lightness returns in the same cycle.
    assign load_intx_o = w_obj.hflip ? (IW'(OBJ_W - 1) - r_cnt[IW-1:0]) : r_cnt[IW-1:0];
    assign load_inty_o = IW'(r_back_y - w_obj.y);

    assign ready_o    = r_ready;
    assign overflow_o = r_overflow;
    assign pixel_o    = r_pixel;

    // Bank storage: clear sweep or object pixel write into the back bank.
    always_ff @(posedge gpu_clk) begin
        // NOTE: the line storage has no reset; the CLEAR sweep initialises it and front_valid masks stale data.
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[w_clr_idx] <= '0;
            end else if (w_pix_we) begin
                r_mem[w_back_idx] <= {1'b1, load_lightness_i, w_obj.color};
            end
        end
    end

    // Control FSM: bank swap, back-bank clear sweep and per-object draw.
    always_ff @(posedge gpu_clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state       <= CLEAR;
            r_ready       <= 1'b0;
            r_cnt         <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_front_sel   <= 1'b0;
            r_front_valid <= 1'b0;
            r_front_y     <= '0;
            r_back_y      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (swap_i) begin
                        r_front_sel   <= ~r_front_sel;
                        r_front_y     <= r_back_y;
                        r_back_y      <= new_y_i;
                        r_overflow    <= 1'b0;
                        r_count       <= '0;
                        r_front_valid <= 1'b1;
                        r_cnt         <= '0;
                        r_ready       <= 1'b0;
                        r_state       <= CLEAR;
                    end else if (load_start_i) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= LOAD;
                    end
                end

                CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(LINE_W - 1)) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                LOAD: begin
                    if (!w_hit) begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_overflowing) begin
                        r_overflow <= 1'b1;
                        r_ready    <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        if (w_first) begin
                            r_count <= r_count + CW'(1);
                        end
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    // Registered display readout of the front bank.
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_pixel <= '0;
        end else begin
            r_pixel <= w_disp_hit ? r_mem[w_front_idx].pixel : '0;
        end
    end

endmodule

// File: tb/tb_object_line_buffer.sv
// Testbench for object_line_buffer: scenario tasks drive stimulus, a
// line-level model predicts bank contents, and queues carry the expected
// pixel and pattern-coordinate streams to the point of comparison.

module tb_object_line_buffer;
    import mapache64::*;

    localparam int LINE_W   = 256;
    localparam int OBJ_W    = 8;
    localparam int MAX_OBJS = 16;

    logic        gpu_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        ready_o;
    logic        swap_i = 1'b0;
    logic [7:0]  new_y_i = '0;
    logic        load_start_i = 1'b0;
    obm_object_t load_object_i = '0;
    logic [2:0]  load_intx_o;
    logic [2:0]  load_inty_o;
    logic [1:0]  load_lightness_i = '0;
    logic [7:0]  display_x_i = '0;
    logic [7:0]  display_y_i = '0;
    pixel_t      pixel_o;
    logic        overflow_o;

    object_line_buffer #(
        .LINE_W  (LINE_W),
        .OBJ_W   (OBJ_W),
        .MAX_OBJS(MAX_OBJS)
    ) dut (
        .gpu_clk         (gpu_clk),
        .rst             (rst),
        .ready_o         (ready_o),
        .swap_i          (swap_i),
        .new_y_i         (new_y_i),
        .load_start_i    (load_start_i),
        .load_object_i   (load_object_i),
        .load_intx_o     (load_intx_o),
        .load_inty_o     (load_inty_o),
        .load_lightness_i(load_lightness_i),
        .display_x_i     (display_x_i),
        .display_y_i     (display_y_i),
        .pixel_o         (pixel_o),
        .overflow_o      (overflow_o)
    );

    always #5 gpu_clk = ~gpu_clk;

    int n_vec = 0;
    int n_err = 0;

    pixel_t exp_pix_q[$];
    int     exp_intx_q[$];

    // Line model: {occupied, lightness, color} per x.
    logic [6:0] m_back  [LINE_W];
    logic [6:0] m_front [LINE_W];
    logic [7:0] m_back_y, m_front_y;
    bit         m_front_valid;
    int         m_count;
    bit         m_overflow;

    task automatic tick();
        @(posedge gpu_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINE_W; i++) begin
            m_back[i]  = '0;
            m_front[i] = '0;
        end
        m_back_y = '0; m_front_y = '0; m_front_valid = 0; m_count = 0; m_overflow = 0;
    endtask

    task automatic model_swap(input logic [7:0] y);
        for (int i = 0; i < LINE_W; i++) begin
            m_front[i] = m_back[i];
            m_back[i]  = '0;
        end
        m_front_y = m_back_y; m_back_y = y; m_front_valid = 1; m_count = 0; m_overflow = 0;
    endtask

    task automatic model_load(input obm_object_t o, input logic [15:0] light, output int cyc);
        int a;
        int ic;
        cyc = 1;
        if (!(int'(o.y) <= int'(m_back_y) && int'(m_back_y) <= int'(o.y) + OBJ_W - 1)) return;
        if (m_count == MAX_OBJS) begin
            m_overflow = 1;
            return;
        end
        m_count++;
        cyc = 0;
        for (int c = 0; c < OBJ_W; c++) begin
            cyc++;
            a  = int'(o.x) + c;
            ic = o.hflip ? OBJ_W - 1 - c : c;
            if (a < LINE_W) begin
                if (light[2*ic +: 2] != 2'd0 && !m_back[a][6])
                    m_back[a] = {1'b1, light[2*ic +: 2], o.color};
            end
            if (a == LINE_W - 1) break;
        end
    endtask

    // Wait (bounded) for ready_o; returns the number of clock edges waited.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready_o !== 1'b1 && cyc < 2 * LINE_W) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_swap(input logic [7:0] y, input bit with_load, input string name);
        int cyc;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before_swap: got %b expected 1", name, ready_o);
        end
        swap_i = 1'b1; new_y_i = y; load_start_i = with_load;
        tick();
        swap_i = 1'b0;
        cyc = 0;
        while (ready_o !== 1'b1 && cyc < 2 * LINE_W) begin
            if (cyc == 10) load_start_i = 1'b0;
            tick();
            cyc++;
        end
        load_start_i = 1'b0;
        model_swap(y);
        n_vec++;
        if (cyc != LINE_W) begin
            n_err++;
            $display("FAIL %s clear_cycles: got %0d expected %0d", name, cyc, LINE_W);
        end
        n_vec++;
        if (overflow_o !== m_overflow) begin
            n_err++;
            $display("FAIL %s overflow_after_swap: got %b expected %b", name, overflow_o, m_overflow);
        end
    endtask

    task automatic do_load(input obm_object_t o, input logic [15:0] light, input string name);
        int     exp_cyc;
        int     cyc;
        int     ex;
        logic [2:0] exp_inty;
        exp_inty = 3'(m_back_y - o.y);
        model_load(o, light, exp_cyc);
        exp_intx_q.delete();
        for (int k = 0; k < exp_cyc; k++) exp_intx_q.push_back(o.hflip ? OBJ_W - 1 - k : k);
        load_object_i = o;
        load_start_i  = 1'b1;
        tick();
        load_start_i  = 1'b0;
        cyc = 0;
        while (ready_o !== 1'b1 && cyc < 40) begin
            if (exp_intx_q.size() > 0) begin
                ex = exp_intx_q.pop_front();
                n_vec++;
                if (load_intx_o !== 3'(ex) || load_inty_o !== exp_inty) begin
                    n_err++;
                    $display("FAIL %s intx/inty[%0d]: got %0d/%0d expected %0d/%0d",
                             name, cyc, load_intx_o, load_inty_o, ex, exp_inty);
                end
            end
            load_lightness_i = light[2*int'(load_intx_o) +: 2];
            tick();
            cyc++;
        end
        load_lightness_i = '0;
        n_vec++;
        if (cyc != exp_cyc) begin
            n_err++;
            $display("FAIL %s load_cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        n_vec++;
        if (overflow_o !== m_overflow) begin
            n_err++;
            $display("FAIL %s overflow: got %b expected %b", name, overflow_o, m_overflow);
        end
    endtask

    // Scan a whole display line; expected pixels queued as positions are driven.
    task automatic scan_line(input logic [7:0] y, input string name);
        pixel_t e;
        for (int x = 0; x < LINE_W; x++) begin
            display_x_i = 8'(x);
            display_y_i = y;
            exp_pix_q.push_back((m_front_valid && y == m_front_y) ? pixel_t'(m_front[x][5:0]) : pixel_t'('0));
            tick();
            e = exp_pix_q.pop_front();
            n_vec++;
            if (pixel_o !== e) begin
                n_err++;
                $display("FAIL %s pixel y=%0d x=%0d: got %h expected %h", name, y, x, pixel_o, e);
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        n_vec++;
        if (ready_o !== 1'b0 || pixel_o !== 6'h00 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b pixel=%h ovf=%b expected 0/00/0", ready_o, pixel_o, overflow_o);
        end
        rst = 1'b0;
        wait_ready(cyc);
        n_vec++;
        if (cyc != LINE_W) begin
            n_err++;
            $display("FAIL reset_ready_latency: got %0d expected %0d", cyc, LINE_W);
        end
        scan_line(8'd0, "reset");
    endtask

    task automatic test_basic();
        obm_object_t o;
        do_swap(8'd10, 0, "basic_swap1");
        o = '{x: 8'd20, y: 8'd5, color: 4'd3, hflip: 1'b0};
        do_load(o, 16'h5555, "basic_load");
        do_swap(8'd11, 0, "basic_swap2");
        display_x_i = 8'd24; display_y_i = 8'd10;
        tick();
        n_vec++;
        if (pixel_o !== 6'h13) begin
            n_err++;
            $display("FAIL basic_x24: got %h expected 13", pixel_o);
        end
        scan_line(8'd10, "basic_line");
        scan_line(8'd11, "basic_wrong_y");
    endtask

    task automatic test_hflip_miss();
        obm_object_t o;
        do_swap(8'd10, 0, "hflip_swap");
        o = '{x: 8'd100, y: 8'd5, color: 4'd4, hflip: 1'b1};
        do_load(o, 16'h1B6C, "hflip_load");
        o = '{x: 8'd120, y: 8'd2, color: 4'd7, hflip: 1'b0};
        do_load(o, 16'h5555, "miss_above");
        o = '{x: 8'd130, y: 8'd11, color: 4'd7, hflip: 1'b0};
        do_load(o, 16'h5555, "miss_below");
        o = '{x: 8'd140, y: 8'd3, color: 4'd8, hflip: 1'b1};
        do_load(o, 16'hFFFF, "hit_last_row");
        do_swap(8'd20, 0, "hflip_swap2");
        scan_line(8'd10, "hflip_line");
    endtask

    task automatic test_overlap();
        obm_object_t o;
        o = '{x: 8'd40, y: 8'd20, color: 4'd2, hflip: 1'b0};
        do_load(o, 16'h5155, "overlap_a");
        o = '{x: 8'd44, y: 8'd17, color: 4'd5, hflip: 1'b0};
        do_load(o, 16'hAAAA, "overlap_b");
        do_swap(8'd21, 0, "overlap_swap");
        display_y_i = 8'd20;
        display_x_i = 8'd44; tick();
        n_vec++;
        if (pixel_o !== 6'h12) begin
            n_err++;
            $display("FAIL overlap_x44: got %h expected 12", pixel_o);
        end
        display_x_i = 8'd45; tick();
        n_vec++;
        if (pixel_o !== 6'h25) begin
            n_err++;
            $display("FAIL overlap_x45: got %h expected 25", pixel_o);
        end
        scan_line(8'd20, "overlap_line");
    endtask

    task automatic test_edge();
        obm_object_t o;
        o = '{x: 8'd252, y: 8'd21, color: 4'd6, hflip: 1'b0};
        do_load(o, 16'h5555, "edge_load");
        do_swap(8'd22, 0, "edge_swap");
        display_y_i = 8'd21; display_x_i = 8'd255; tick();
        n_vec++;
        if (pixel_o !== 6'h16) begin
            n_err++;
            $display("FAIL edge_x255: got %h expected 16", pixel_o);
        end
        scan_line(8'd21, "edge_line");
    endtask

    task automatic test_overflow();
        obm_object_t o;
        for (int i = 0; i < MAX_OBJS; i++) begin
            o = '{x: 8'(i * 8), y: 8'(22 - (i % 8)), color: 4'(i), hflip: 1'(i % 2)};
            do_load(o, 16'(16'h5555 * (i % 3 + 1)), $sformatf("ovf_obj%0d", i));
        end
        o = '{x: 8'd200, y: 8'd22, color: 4'd9, hflip: 1'b0};
        do_load(o, 16'h5555, "ovf_extra");
        o = '{x: 8'd210, y: 8'd100, color: 4'd9, hflip: 1'b0};
        do_load(o, 16'h5555, "ovf_sticky_miss");
        o = '{x: 8'd220, y: 8'd30, color: 4'd1, hflip: 1'b0};
        load_object_i = o;
        do_swap(8'd30, 1, "swap_beats_load");
        scan_line(8'd22, "ovf_line");
    endtask

    task automatic test_reset_mid();
        obm_object_t o;
        int cyc;
        o = '{x: 8'd60, y: 8'd30, color: 4'd7, hflip: 1'b0};
        load_object_i = o;
        load_start_i  = 1'b1;
        tick();
        load_start_i  = 1'b0;
        load_lightness_i = 2'd1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        load_lightness_i = 2'd0;
        n_vec++;
        if (ready_o !== 1'b0 || pixel_o !== 6'h00 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: got ready=%b pixel=%h ovf=%b expected 0/00/0", ready_o, pixel_o, overflow_o);
        end
        rst = 1'b0;
        model_reset();
        wait_ready(cyc);
        n_vec++;
        if (cyc != LINE_W) begin
            n_err++;
            $display("FAIL midreset_ready_latency: got %0d expected %0d", cyc, LINE_W);
        end
        scan_line(8'd0, "midreset_invalid");
        do_swap(8'd40, 0, "midreset_swap");
        scan_line(8'd0, "midreset_cleared");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hflip_miss();
        test_overlap();
        test_edge();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
